// File: rtl/llc_tag_lookup_pkg.sv
// Shared types and default geometry for the LLC tag/state store.
package llc_tag_lookup_pkg;

  localparam int unsigned ADDR_SIZE_DEF  = 32;
  localparam int unsigned LINE_BYTES_DEF = 64;
  localparam int unsigned N_SETS_DEF     = 16;
  localparam int unsigned N_WAY_DEF      = 8;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  // Encoding 3 is reserved and behaves as a read.
  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_SNOOP_INV = 2'd2,
    OP_RSVD      = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

endpackage

// File: rtl/llc_tag_lookup_plru_tree.sv
// Tree pseudo-LRU: victim walk and touch update over heap-ordered node bits.
// Node n has children 2n+1 (bit 0) and 2n+2 (bit 1); a bit points at the victim side.
module llc_tag_lookup_plru_tree
  import llc_tag_lookup_pkg::*;
#(
  parameter int unsigned N_WAY = N_WAY_DEF,
  localparam int unsigned WAY_W = $clog2(N_WAY)
) (
  input  logic [N_WAY-2:0] plru,
  input  logic [WAY_W-1:0] acc_way,
  output logic [WAY_W-1:0] victim_c,
  output logic [N_WAY-2:0] plru_next_c
);

  logic [WAY_W-1:0] vnode;
  logic [WAY_W-1:0] tnode;
  logic             dir;

  // Follow the node bits from the root down to a leaf.
  always_comb begin
    victim_c = '0;
    vnode    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_c[WAY_W-1-l] = plru[vnode];
      vnode = WAY_W'(2 * int'(vnode) + 1 + int'(plru[vnode]));
    end
  end

  // Point every node on the accessed way's path away from it.
  always_comb begin
    plru_next_c = plru;
    tnode       = '0;
    dir         = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = acc_way[WAY_W-1-l];
      plru_next_c[tnode] = ~dir;
      tnode = WAY_W'(2 * int'(tnode) + 1 + int'(dir));
    end
  end

endmodule

// File: rtl/llc_tag_lookup.sv
// Set-associative LLC tag/state store: MESI updates, tree-PLRU replacement,
// one request per three cycles with a single-cycle response strobe.
module llc_tag_lookup
  import llc_tag_lookup_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
  parameter int unsigned N_SETS     = N_SETS_DEF,
  parameter int unsigned N_WAY      = N_WAY_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_SIZE-1:0]       req_addr,
  input  logic [1:0]                 req_op,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
  output logic [$clog2(N_WAY)-1:0]   rsp_way,
  output logic [1:0]                 rsp_mesi_prev,
  output logic                       rsp_evict_valid,
  output logic [ADDR_SIZE-1:0]       rsp_evict_addr,
  output logic                       rsp_evict_dirty,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
);

  localparam int unsigned OFFSET_W = $clog2(LINE_BYTES);
  localparam int unsigned INDEX_W  = $clog2(N_SETS);
  localparam int unsigned TAG_W    = ADDR_SIZE - OFFSET_W - INDEX_W;
  localparam int unsigned WAY_W    = $clog2(N_WAY);

  typedef struct packed {
    logic             valid;
    mesi_e            mesi;
    logic [TAG_W-1:0] tag;
  } line_t;

  state_e               state_q;
  logic [INDEX_W-1:0]   clr_idx_q;
  logic [INDEX_W-1:0]   idx_q;
  logic [TAG_W-1:0]     tag_q;
  op_e                  op_q;

  line_t [N_WAY-1:0]    ways_q [N_SETS];
  logic  [N_WAY-2:0]    plru_q [N_SETS];

  line_t [N_WAY-1:0]    set_q;
  logic  [N_WAY-2:0]    plru_set_q;
  logic  [N_WAY-1:0]    hit_vec_q;

  line_t [N_WAY-1:0]    cur_set;
  logic  [N_WAY-1:0]    hit_vec;
  logic                 hit;
  logic                 has_inv;
  logic                 is_snoop;
  logic                 is_write;
  logic                 evict_valid;
  logic                 evict_dirty;
  logic                 wr_en;
  logic [WAY_W-1:0]     hit_way;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     plru_victim;
  logic [WAY_W-1:0]     fill_way;
  logic [WAY_W-1:0]     acc_way;
  logic [WAY_W-1:0]     out_way;
  logic [N_WAY-2:0]     plru_next;
  logic [N_WAY-2:0]     plru_wr;
  mesi_e                prev_mesi;
  line_t                victim_line;
  line_t                new_line;
  logic                 unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  // Tag compare against the indexed set during LOOKUP.
  always_comb begin
    cur_set = ways_q[idx_q];
    for (int w = 0; w < N_WAY; w++) begin
      hit_vec[w] = cur_set[w].valid && (cur_set[w].tag == tag_q);
    end
  end

  // Hit way and lowest-numbered invalid way from the registered set.
  always_comb begin
    hit      = |hit_vec_q;
    is_snoop = (op_q == OP_SNOOP_INV);
    is_write = (op_q == OP_WRITE);
    hit_way  = '0;
    inv_way  = '0;
    has_inv  = 1'b0;
    for (int w = N_WAY - 1; w >= 0; w--) begin
      if (hit_vec_q[w]) begin
        hit_way = WAY_W'(w);
      end
      if (!set_q[w].valid) begin
        inv_way = WAY_W'(w);
        has_inv = 1'b1;
      end
    end
  end

  llc_tag_lookup_plru_tree #(
    .N_WAY (N_WAY)
  ) u_plru (
    .plru        (plru_set_q),
    .acc_way     (acc_way),
    .victim_c    (plru_victim),
    .plru_next_c (plru_next)
  );

  assign fill_way = has_inv ? inv_way : plru_victim;
  assign acc_way  = hit ? hit_way : fill_way;
  assign plru_wr  = is_snoop ? plru_set_q : plru_next;

  // New line contents, victim details and response fields for UPDATE.
  always_comb begin
    out_way     = (hit || !is_snoop) ? acc_way : '0;
    prev_mesi   = hit ? set_q[hit_way].mesi : MESI_I;
    victim_line = set_q[fill_way];
    evict_valid = !hit && !is_snoop && !has_inv;
    evict_dirty = evict_valid && (victim_line.mesi == MESI_M);
    wr_en       = hit || !is_snoop;
    new_line    = set_q[acc_way];
    if (is_snoop) begin
      new_line.valid = 1'b0;
      new_line.mesi  = MESI_I;
    end else if (hit) begin
      if (is_write) begin
        new_line.mesi = MESI_M;
      end
    end else begin
      new_line.valid = 1'b1;
      new_line.mesi  = is_write ? MESI_M : MESI_E;
      new_line.tag   = tag_q;
    end
  end

  // Control FSM, arrays, response registers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_CLEAR;
      clr_idx_q       <= '0;
      idx_q           <= '0;
      tag_q           <= '0;
      op_q            <= OP_READ;
      set_q           <= '0;
      plru_set_q      <= '0;
      hit_vec_q       <= '0;
      req_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_way         <= '0;
      rsp_mesi_prev   <= 2'b00;
      rsp_evict_valid <= 1'b0;
      rsp_evict_addr  <= '0;
      rsp_evict_dirty <= 1'b0;
      hit_count       <= 32'd0;
      miss_count      <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          ways_q[clr_idx_q] <= '0;
          plru_q[clr_idx_q] <= '0;
          clr_idx_q         <= clr_idx_q + INDEX_W'(1);
          if (clr_idx_q == INDEX_W'(N_SETS - 1)) begin
            state_q   <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            tag_q     <= req_addr[ADDR_SIZE-1 -: TAG_W];
            idx_q     <= req_addr[OFFSET_W +: INDEX_W];
            op_q      <= op_e'(req_op);
            req_ready <= 1'b0;
            state_q   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          set_q      <= cur_set;
          plru_set_q <= plru_q[idx_q];
          hit_vec_q  <= hit_vec;
          state_q    <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (wr_en) begin
            ways_q[idx_q][acc_way] <= new_line;
          end
          plru_q[idx_q]   <= plru_wr;
          rsp_valid       <= 1'b1;
          rsp_hit         <= hit;
          rsp_way         <= out_way;
          rsp_mesi_prev   <= prev_mesi;
          rsp_evict_valid <= evict_valid;
          rsp_evict_addr  <= {victim_line.tag, idx_q, OFFSET_W'(0)};
          rsp_evict_dirty <= evict_dirty;
          if (!is_snoop) begin
            if (hit) begin
              if (hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
              end
            end else if (miss_count != 32'hFFFF_FFFF) begin
              miss_count <= miss_count + 32'd1;
            end
          end
          req_ready <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_tag_lookup.sv
// Directed bench for llc_tag_lookup: vector table plus reset/timing sequences.
module tb_llc_tag_lookup;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_op;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [2:0]  rsp_way;
  logic [1:0]  rsp_mesi_prev;
  logic        rsp_evict_valid;
  logic [31:0] rsp_evict_addr;
  logic        rsp_evict_dirty;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        rst_before;
    logic [1:0]  op;
    logic [31:0] addr;
    logic        hit;
    logic [2:0]  way;
    logic [1:0]  prev;
    logic        ev_valid;
    logic [31:0] ev_addr;
    logic        ev_dirty;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t vecs [$];

  llc_tag_lookup dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_op          (req_op),
    .rsp_valid       (rsp_valid),
    .rsp_hit         (rsp_hit),
    .rsp_way         (rsp_way),
    .rsp_mesi_prev   (rsp_mesi_prev),
    .rsp_evict_valid (rsp_evict_valid),
    .rsp_evict_addr  (rsp_evict_addr),
    .rsp_evict_dirty (rsp_evict_dirty),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic rb, input logic [1:0] op, input logic [31:0] addr,
                         input logic hit, input logic [2:0] way, input logic [1:0] prev,
                         input logic evv, input logic [31:0] eva, input logic evd,
                         input logic [31:0] h, input logic [31:0] m);
    vec_t v;
    v.rst_before = rb;  v.op = op;     v.addr = addr;
    v.hit = hit;        v.way = way;   v.prev = prev;
    v.ev_valid = evv;   v.ev_addr = eva; v.ev_dirty = evd;
    v.hits = h;         v.misses = m;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (!req_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    check($sformatf("%s ready before request", name), 32'(req_ready), 32'd1);
  endtask

  // Count cycles from reset release until req_ready; also watch for stray responses.
  task automatic clear_wait(input string name);
    int cnt;
    logic seen_rsp;
    seen_rsp = 1'b0;
    tick();
    cnt = 1;
    if (rsp_valid) seen_rsp = 1'b1;
    while (!req_ready && cnt < 100) begin
      tick();
      cnt++;
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check($sformatf("%s clear cycles", name), 32'(cnt), 32'd16);
    check($sformatf("%s no rsp during clear", name), 32'(seen_rsp), 32'd0);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    check($sformatf("%s hit_count in reset", name), hit_count, 32'd0);
    check($sformatf("%s miss_count in reset", name), miss_count, 32'd0);
    rst = 1'b0;
    clear_wait(name);
  endtask

  // Accept at edge N, expect the strobe only after edge N+2.
  task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] addr);
    wait_ready(name);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    check($sformatf("%s ready low after accept", name), 32'(req_ready), 32'd0);
    tick();
    check($sformatf("%s rsp_valid early", name), 32'(rsp_valid), 32'd0);
    tick();
    check($sformatf("%s rsp_valid", name), 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    string nm;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'd0;
    req_op = 2'd0;

    // Group A: one line in set 1, op 3 behaves as READ, WRITE hit upgrades E->M.
    add_vec(1'b0, 2'd0, 32'h1040, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd1);
    add_vec(1'b0, 2'd0, 32'h1040, 1'b1, 3'd0, 2'd2, 1'b0, 32'h0, 1'b0, 32'd1, 32'd1);
    add_vec(1'b0, 2'd3, 32'h1040, 1'b1, 3'd0, 2'd2, 1'b0, 32'h0, 1'b0, 32'd2, 32'd1);
    add_vec(1'b0, 2'd1, 32'h1040, 1'b1, 3'd0, 2'd2, 1'b0, 32'h0, 1'b0, 32'd3, 32'd1);
    add_vec(1'b0, 2'd0, 32'h1040, 1'b1, 3'd0, 2'd3, 1'b0, 32'h0, 1'b0, 32'd4, 32'd1);
    // Group B: fill set 1 with READs, then PLRU eviction twice.
    for (int t = 0; t < 8; t++) begin
      add_vec((t == 0), 2'd0, (32'(t) << 10) | 32'h40, 1'b0, 3'(t), 2'd0,
              1'b0, 32'h0, 1'b0, 32'd0, 32'(t + 1));
    end
    add_vec(1'b0, 2'd0, 32'h2040, 1'b0, 3'd0, 2'd0, 1'b1, 32'h0040, 1'b0, 32'd0, 32'd9);
    add_vec(1'b0, 2'd0, 32'h0040, 1'b0, 3'd4, 2'd0, 1'b1, 32'h1040, 1'b0, 32'd0, 32'd10);
    add_vec(1'b0, 2'd0, 32'h2040, 1'b1, 3'd0, 2'd2, 1'b0, 32'h0, 1'b0, 32'd1, 32'd10);
    // Group C: snoop invalidations in set 2.
    add_vec(1'b1, 2'd1, 32'h2080, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd1);
    add_vec(1'b0, 2'd2, 32'h2080, 1'b1, 3'd0, 2'd3, 1'b0, 32'h0, 1'b0, 32'd0, 32'd1);
    add_vec(1'b0, 2'd0, 32'h2080, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd2);
    add_vec(1'b0, 2'd2, 32'h3080, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd2);
    add_vec(1'b0, 2'd2, 32'h2080, 1'b1, 3'd0, 2'd2, 1'b0, 32'h0, 1'b0, 32'd0, 32'd2);
    add_vec(1'b0, 2'd0, 32'h2080, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd3);
    // Group D: fill set 2 with WRITEs, dirty eviction, then a write hit on M.
    for (int t = 0; t < 8; t++) begin
      add_vec((t == 0), 2'd1, (32'(t) << 10) | 32'h80, 1'b0, 3'(t), 2'd0,
              1'b0, 32'h0, 1'b0, 32'd0, 32'(t + 1));
    end
    add_vec(1'b0, 2'd1, 32'h2080, 1'b0, 3'd0, 2'd0, 1'b1, 32'h0080, 1'b1, 32'd0, 32'd9);
    add_vec(1'b0, 2'd1, 32'h0480, 1'b1, 3'd1, 2'd3, 1'b0, 32'h0, 1'b0, 32'd1, 32'd9);

    // Reset values, then CLEAR length.
    tick();
    tick();
    tick();
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_hit", 32'(rsp_hit), 32'd0);
    check("reset rsp_way", 32'(rsp_way), 32'd0);
    check("reset rsp_evict_valid", 32'(rsp_evict_valid), 32'd0);
    check("reset rsp_evict_addr", rsp_evict_addr, 32'd0);
    check("reset hit_count", hit_count, 32'd0);
    check("reset miss_count", miss_count, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("clear ready cycle %0d", k), 32'(req_ready), (k == 16) ? 32'd1 : 32'd0);
    end

    foreach (vecs[i]) begin
      nm = $sformatf("vec%0d", i);
      if (vecs[i].rst_before) do_reset(nm);
      run_req(nm, vecs[i].op, vecs[i].addr);
      check($sformatf("%s hit", nm), 32'(rsp_hit), 32'(vecs[i].hit));
      check($sformatf("%s way", nm), 32'(rsp_way), 32'(vecs[i].way));
      check($sformatf("%s mesi_prev", nm), 32'(rsp_mesi_prev), 32'(vecs[i].prev));
      check($sformatf("%s evict_valid", nm), 32'(rsp_evict_valid), 32'(vecs[i].ev_valid));
      if (vecs[i].ev_valid) begin
        check($sformatf("%s evict_addr", nm), rsp_evict_addr, vecs[i].ev_addr);
        check($sformatf("%s evict_dirty", nm), 32'(rsp_evict_dirty), 32'(vecs[i].ev_dirty));
      end
      check($sformatf("%s hit_count", nm), hit_count, vecs[i].hits);
      check($sformatf("%s miss_count", nm), miss_count, vecs[i].misses);
    end

    // Strobe lasts one cycle while the response fields hold.
    tick();
    check("hold rsp_valid dropped", 32'(rsp_valid), 32'd0);
    check("hold rsp_hit", 32'(rsp_hit), 32'd1);
    check("hold rsp_way", 32'(rsp_way), 32'd1);

    // Reset while the request sits in LOOKUP.
    wait_ready("rst_lookup");
    req_valid = 1'b1;
    req_op = 2'd0;
    req_addr = 32'h0480;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_lookup rsp_valid a", 32'(rsp_valid), 32'd0);
    tick();
    check("rst_lookup rsp_valid b", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    clear_wait("rst_lookup");
    run_req("rst_lookup reread", 2'd0, 32'h0480);
    check("rst_lookup reread hit", 32'(rsp_hit), 32'd0);
    check("rst_lookup reread way", 32'(rsp_way), 32'd0);
    check("rst_lookup reread evict", 32'(rsp_evict_valid), 32'd0);
    check("rst_lookup miss_count", miss_count, 32'd1);

    // Reset while the request sits in UPDATE.
    wait_ready("rst_update");
    req_valid = 1'b1;
    req_op = 2'd0;
    req_addr = 32'h0480;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_update rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_update hit_count", hit_count, 32'd0);
    check("rst_update miss_count", miss_count, 32'd0);
    rst = 1'b0;
    clear_wait("rst_update");
    run_req("rst_update reread", 2'd0, 32'h0480);
    check("rst_update reread hit", 32'(rsp_hit), 32'd0);
    check("rst_update reread miss_count", miss_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
